avg_threshold_detector: RTL and testbench

- Downstream consumer of the moving-average stage: takes each 10-bit averaged sample and its one-cycle valid strobe.
- Applies a hysteresis window (high/low thresholds) with N-sample debounce.
- Outputs a debounced level, rise/fall event pulses and a saturating event counter for the chip-level outputs.

---
 rtl/avg_thr_pkg.sv | 21 ++
 rtl/thr_debounce_ctr.sv | 25 ++
 rtl/avg_threshold_detector.sv | 101 ++++++++++
 tb/tb_avg_threshold_detector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/avg_thr_pkg.sv
// avg_thr_pkg: shared state encoding, default widths and saturating increment
// for the averaged-sample threshold detector.
package avg_thr_pkg;

    localparam int unsigned DATA_W_DEF = 10;
    localparam int unsigned DBC_W      = 4;

    // level_o is state[1]: both HIGH-side states (HIGH, ARM_LOW) carry a 1 there
    typedef enum logic [1:0] {
        ST_LOW      = 2'b00,
        ST_ARM_HIGH = 2'b01,
        ST_HIGH     = 2'b11,
        ST_ARM_LOW  = 2'b10
    } state_t;

    // holds at 2^w-1 instead of wrapping; w must be below 32
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        return (v == ((32'd1 << w) - 32'd1)) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/thr_debounce_ctr.sv
// thr_debounce_ctr: consecutive-qualifying-sample counter.
// Ports: clk, rst_n (sync, active low), inc (qualifying valid sample),
// clr (restart count, wins over inc), hit (this inc completes DEBOUNCE_N).
module thr_debounce_ctr
    import avg_thr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    logic [DBC_W-1:0] cnt;

    assign hit = inc && (cnt == DBC_W'(DEBOUNCE_N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (inc)      cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/avg_threshold_detector.sv
// avg_threshold_detector: hysteresis threshold detector with N-sample debounce
// on the averager's valid-strobed samples.
// Ports: clk, rst_n (sync, active low), sample_i/sample_valid_i (averaged sample
// and strobe), thr_high_i/thr_low_i (rise/fall thresholds), clear_i (sync clear),
// level_o (debounced level), rise_o/fall_o (1-cycle event pulses),
// event_count_o (saturating rise+fall count), cfg_err_o (thr_low_i > thr_high_i),
// max_o/min_o (running extremes when MINMAX_TRACK_EN is defined, else 0).
module avg_threshold_detector
    import avg_thr_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEBOUNCE_N = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] thr_high_i,
    input  logic [DATA_W-1:0] thr_low_i,
    input  logic              clear_i,
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic [CNT_W-1:0]  event_count_o,
    output logic              cfg_err_o,
    output logic [DATA_W-1:0] max_o,
    output logic [DATA_W-1:0] min_o
);

    state_t state_q, state_d;
    logic   above, below, inc, clr, hit, rise_d, fall_d;

    assign cfg_err_o = thr_low_i > thr_high_i;
    assign above     = sample_i >= thr_high_i;
    assign below     = sample_i <= thr_low_i;
    assign level_o   = state_q[1];

    thr_debounce_ctr #(.DEBOUNCE_N(DEBOUNCE_N)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .clr   (clr || clear_i),
        .hit   (hit)
    );

    // counter restarts on completion (hit) and on abort back to the base state
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        clr     = 1'b0;
        if (sample_valid_i && !cfg_err_o) begin
            case (state_q)
                ST_LOW, ST_ARM_HIGH: begin
                    inc     = above;
                    clr     = !above || hit;
                    state_d = !above ? ST_LOW : (hit ? ST_HIGH : ST_ARM_HIGH);
                end
                ST_HIGH, ST_ARM_LOW: begin
                    inc     = below;
                    clr     = !below || hit;
                    state_d = !below ? ST_HIGH : (hit ? ST_LOW : ST_ARM_LOW);
                end
                default: state_d = ST_LOW;
            endcase
        end
        rise_d = (state_d == ST_HIGH) && !state_q[1];
        fall_d = (state_d == ST_LOW) && state_q[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            state_q       <= ST_LOW;
            rise_o        <= 1'b0;
            fall_o        <= 1'b0;
            event_count_o <= '0;
        end else begin
            state_q <= state_d;
            rise_o  <= rise_d;
            fall_o  <= fall_d;
            if (rise_d || fall_d) event_count_o <= CNT_W'(sat_inc(32'(event_count_o), CNT_W));
        end
    end

`ifdef MINMAX_TRACK_EN
    // tracks every valid sample, regardless of cfg_err_o
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            max_o <= '0;
            min_o <= '1;
        end else if (sample_valid_i) begin
            if (sample_i > max_o) max_o <= sample_i;
            if (sample_i < min_o) min_o <= sample_i;
        end
    end
`else
    assign max_o = '0;
    assign min_o = '0;
`endif

endmodule

// File: tb/tb_avg_threshold_detector.sv
// tb_avg_threshold_detector: table vectors, corner sequences and random stimulus
// checked against a streak-counting reference model.
module tb_avg_threshold_detector;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sample = '0;
    logic       valid = 1'b0;
    logic [9:0] thr_hi = 10'd600;
    logic [9:0] thr_lo = 10'd400;
    logic       clear = 1'b0;
    logic       level, rise, fall, cfg_err;
    logic [7:0] cnt;
    logic [9:0] max_v, min_v;

    int checks = 0;
    int failures = 0;

    int m_level, m_streak, m_cnt, m_rise, m_fall, m_max, m_min;

    typedef struct {
        logic       v;
        logic [9:0] s;
        int         lvl;
        int         r;
        int         f;
        int         c;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    avg_threshold_detector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_i       (sample),
        .sample_valid_i (valid),
        .thr_high_i     (thr_hi),
        .thr_low_i      (thr_lo),
        .clear_i        (clear),
        .level_o        (level),
        .rise_o         (rise),
        .fall_o         (fall),
        .event_count_o  (cnt),
        .cfg_err_o      (cfg_err),
        .max_o          (max_v),
        .min_o          (min_v)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_streak = 0; m_cnt = 0; m_rise = 0; m_fall = 0;
`ifdef MINMAX_TRACK_EN
        m_max = 0; m_min = 1023;
`else
        m_max = 0; m_min = 0;
`endif
    endtask

    // one clock: drive, advance, update the model with the pre-edge inputs, compare
    task automatic step(input logic rn, input logic v, input logic [9:0] s, input logic c);
        rst_n = rn; valid = v; sample = s; clear = c;
        @(posedge clk);
        #1;
        if (!rn || c) model_reset();
        else begin
            m_rise = 0; m_fall = 0;
            if (v && !(thr_lo > thr_hi)) begin
                if (m_level != 0 ? (s <= thr_lo) : (s >= thr_hi)) begin
                    m_streak++;
                    if (m_streak == N) begin
                        m_level = 1 - m_level;
                        m_rise = m_level;
                        m_fall = 1 - m_level;
                        m_streak = 0;
                        if (m_cnt < 255) m_cnt++;
                    end
                end else m_streak = 0;
            end
`ifdef MINMAX_TRACK_EN
            if (v) begin
                if (s > m_max) m_max = s;
                if (s < m_min) m_min = s;
            end
`endif
        end
        chk("level", level, m_level);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("count", cnt, m_cnt);
        chk("cfg_err", cfg_err, (thr_lo > thr_hi) ? 1 : 0);
        chk("max", max_v, m_max);
        chk("min", min_v, m_min);
    endtask

    task automatic add(input logic v, input logic [9:0] s, input int l, input int r, input int f, input int c);
        vecs.push_back(vec_t'{v, s, l, r, f, c});
    endtask

    initial begin
        logic tgt;
        logic [9:0] s;
        add(1, 650, 0, 0, 0, 0);
        add(1, 650, 0, 0, 0, 0);
        add(1, 599, 0, 0, 0, 0);
        add(1, 610, 0, 0, 0, 0);
        add(0, 0,   0, 0, 0, 0);
        add(1, 610, 0, 0, 0, 0);
        add(1, 610, 1, 1, 0, 1);
        add(0, 0,   1, 0, 0, 1);
        for (int i = 0; i < 10; i++) add(1, 500, 1, 0, 0, 1);
        add(1, 400, 1, 0, 0, 1);
        add(0, 0,   1, 0, 0, 1);
        add(1, 300, 1, 0, 0, 1);
        add(1, 0,   0, 0, 1, 2);
        add(0, 0,   0, 0, 0, 2);
        add(1, 650, 0, 0, 0, 2);
        add(1, 700, 0, 0, 0, 2);
        add(1, 600, 1, 1, 0, 3);
        add(1, 600, 1, 0, 0, 3);

        model_reset();
        step(0, 1, 10'd1023, 0);
        step(0, 1, 10'd1023, 0);
        chk("rst_level", level, 0);
        chk("rst_rise", rise, 0);
        chk("rst_count", cnt, 0);

        foreach (vecs[i]) begin
            step(1, vecs[i].v, vecs[i].s, 0);
            chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("vec%0d_rise", i), rise, vecs[i].r);
            chk($sformatf("vec%0d_fall", i), fall, vecs[i].f);
            chk($sformatf("vec%0d_count", i), cnt, vecs[i].c);
        end

        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < 3; k++) step(1, 1, 10'd0, 0);
            for (int k = 0; k < 3; k++) step(1, 1, 10'd1023, 0);
        end
        chk("sat_count", cnt, 255);
        chk("sat_level", level, 1);

        step(1, 1, 10'd0, 1);
        chk("clr_count", cnt, 0);
        chk("clr_level", level, 0);
        step(1, 1, 10'd1023, 0);
        step(1, 1, 10'd1023, 0);
        chk("clr_dropped", level, 0);
        step(1, 1, 10'd1023, 0);
        chk("clr_rise", rise, 1);

        step(1, 0, 10'd0, 1);
        thr_lo = 10'd700; thr_hi = 10'd600;
        #1;
        chk("cfg_err_on", cfg_err, 1);
        for (int k = 0; k < 5; k++) step(1, 1, 10'd1023, 0);
        chk("cfg_no_rise", level, 0);
        thr_lo = 10'd400; thr_hi = 10'd600;
        #1;
        chk("cfg_err_off", cfg_err, 0);

        step(1, 0, 10'd0, 1);
        step(1, 1, 10'd5, 0);
        step(1, 1, 10'd1023, 0);
        step(1, 1, 10'd512, 0);
`ifdef MINMAX_TRACK_EN
        chk("minmax_max", max_v, 1023);
        chk("minmax_min", min_v, 5);
`else
        chk("minmax_max", max_v, 0);
        chk("minmax_min", min_v, 0);
`endif

        tgt = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                thr_lo = 10'($urandom_range(300, 500));
                thr_hi = 10'($urandom_range(550, 750));
                if ($urandom_range(0, 9) == 0) begin
                    thr_lo = 10'd800;
                    thr_hi = 10'($urandom_range(300, 799));
                end
            end
            if ($urandom_range(0, 9) == 0) tgt = ~tgt;
            if ($urandom_range(0, 4) == 0) s = 10'($urandom_range(0, 1023));
            else s = tgt ? 10'($urandom_range(int'(thr_hi), 1023)) : 10'($urandom_range(0, int'(thr_lo)));
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 1) == 1), s,
                 ($urandom_range(0, 149) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
